// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster pixel stream; result appears two enabled edges after the accept that completes its window.
// A stalled output (out_valid & !out_ready) freezes the whole pipeline and drops in_ready in the same cycle.
module conv3x3_stream #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0,
  parameter int RELU   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIX_W-1:0]      in_data,
  input  logic [9*COEF_W-1:0]   coef,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_last
);
  localparam int ACC_W  = PIX_W + COEF_W + 5;
  localparam int PROD_W = PIX_W + 1 + COEF_W;
  localparam int CMP_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam logic signed [ACC_W-1:0] RND =
    ACC_W'((SHIFT > 0) ? (64'd1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 64'd0);
  localparam logic signed [CMP_W-1:0] UMAX = {{(CMP_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic signed [CMP_W-1:0] SMAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SMIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [9*COEF_W-1:0]       coef_q, coef_d;
  logic [PIX_W-1:0]          lb0_q [IMG_W];
  logic [PIX_W-1:0]          lb1_q [IMG_W];
  logic [PIX_W-1:0]          win_q [3][3];
  logic [PIX_W-1:0]          win_d [3][3];
  logic                      v1_q, v1_d, last1_q, last1_d;
  logic signed [PROD_W-1:0]  prod_q [9];
  logic signed [PROD_W-1:0]  prod_d [9];
  logic                      v2_q, v2_d, last2_q, last2_d;
  logic                      out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [OUT_W-1:0]          out_data_q, out_data_d;
  logic                      en, accept;
  logic signed [ACC_W-1:0]   acc, shifted;
  logic signed [CMP_W-1:0]   sx;
  logic [OUT_W-1:0]          res;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // Sum, round-half-up, arithmetic shift, then clamp in a width that cannot overflow.
  always_comb begin
    acc = '0;
    for (int k = 0; k < 9; k++) acc = acc + ACC_W'(prod_q[k]);
    shifted = (acc + RND) >>> SHIFT;
    sx = CMP_W'(shifted);
    res = sx[OUT_W-1:0];
    if (RELU != 0) begin
      if (sx < 0) res = '0;
      else if (sx > UMAX) res = UMAX[OUT_W-1:0];
    end else begin
      if (sx > SMAX) res = SMAX[OUT_W-1:0];
      else if (sx < SMIN) res = SMIN[OUT_W-1:0];
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    coef_d      = coef_q;
    win_d       = win_q;
    v1_d        = v1_q;
    last1_d     = last1_q;
    prod_d      = prod_q;
    v2_d        = v2_q;
    last2_d     = last2_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (accept) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      if (col_q == '0 && row_q == '0) coef_d = coef;
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb0_q[col_q];
      win_d[1][2] = lb1_q[col_q];
      win_d[2][2] = in_data;
    end
    if (en) begin
      // Edges of the image never form a window, so no wrap-around outputs exist.
      v1_d    = accept && row_q >= ROW_W'(2) && col_q >= COL_W'(2);
      last1_d = accept && row_q == ROW_W'(IMG_H - 1) && col_q == COL_W'(IMG_W - 1);
      for (int k = 0; k < 9; k++)
        prod_d[k] = PROD_W'($signed({1'b0, win_q[k/3][k%3]}))
                  * PROD_W'($signed(coef_q[k*COEF_W +: COEF_W]));
      v2_d        = v1_q;
      last2_d     = last1_q;
      out_valid_d = v2_q;
      out_last_d  = last2_q;
      if (v2_q) out_data_d = res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      coef_q      <= '0;
      win_q       <= '{default: '0};
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      prod_q      <= '{default: '0};
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      coef_q      <= coef_d;
      win_q       <= win_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      prod_q      <= prod_d;
      v2_q        <= v2_d;
      last2_q     <= last2_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Line buffers hold no reset: rows 0-1 of each frame never reach the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= in_data;
    end
  end
endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Parametrised streaming 3x3 convolution engine; successor to the fixed three-line-buffer convolution block.
- Accepts one unsigned pixel per handshake in raster order, keeps two previous image rows in internal ring line buffers, and forms a 3x3 window.
- Computes a signed multiply-accumulate against a per-frame coefficient set, then round/shift, optional ReLU and saturation.
- Emits "valid" (unpadded) outputs through a valid/ready interface with full backpressure. Sits between the pixel source and the pooling/activation stages.

Parameters:
PIX_W, 8, pixel width (unsigned)
COEF_W, 8, coefficient width (signed two's complement)
IMG_W, 100, pixels per row (>=3)
IMG_H, 100, rows per frame (>=3)
OUT_W, 16, output width
SHIFT, 0, arithmetic right shift applied to sum (0..ACC_W-1)
RELU, 0, 1 = clamp negatives to 0 and output unsigned
ACC_W = PIX_W+COEF_W+5 (derived, not overridable)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  pixel available
in_ready  out  1  block can accept pixel
in_data  in  PIX_W  pixel
coef  in  9*COEF_W  kernel; tap k=3*i+j at [k*COEF_W +: COEF_W]; i=0 oldest row, j=0 leftmost column
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_data  out  OUT_W  result (signed if RELU=0, unsigned if RELU=1)
out_last  out  1  high with the final output of a frame

Behaviour:
- Reset values: in_ready=0 during rst and 1 after; out_valid=0, out_data=0, out_last=0. Row/column counters are 0 and all pipeline valid bits are cleared. Line buffer contents are not cleared; they need no clearing because rows 0-1 never produce output.
- Accept = in_valid & in_ready. Advance enable en = !out_valid | out_ready. in_ready = en & !rst. The whole pipeline stalls while en=0; no data is dropped or duplicated.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on accept. col wraps to 0 with row+1. At (IMG_H-1, IMG_W-1) both wrap to 0 and the next frame begins.
- coef is latched into an internal register on accept of pixel (0,0). coef changes mid-frame are ignored.
- Line buffers: two IMG_W-deep memories LB0 (row r-2) and LB1 (row r-1), addressed by col. On accept: read LB0[col] and LB1[col], then write LB0[col] <= old LB1[col] and LB1[col] <= in_data (read-before-write, same edge).
- Window: 3x3 register array. On accept, columns shift left and the new right column {LB0[col], LB1[col], in_data} enters.
- Window valid v1 is set on accept when row>=2 and col>=2; otherwise 0.
- Pipeline, with accept on edge N:
  - edge N: window + v1
  - edge N+1: nine products, each PIX_W+1+COEF_W signed, + v2
  - edge N+2: sum, round, shift, ReLU, saturate into out_data; out_valid=1
  - Output is visible after edge N+2 when not stalled.
- Arithmetic:
  - sum = Σ w[i][j]*coef[3i+j] in ACC_W signed.
  - If SHIFT>0, add 1<<(SHIFT-1) (round half up), then arithmetic shift right by SHIFT.
  - RELU=1: negatives -> 0, saturate to 2^OUT_W-1.
  - RELU=0: saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- out_last is tagged on the window ending at pixel (IMG_H-1, IMG_W-1) and travels with its data.
- Outputs per frame: exactly (IMG_W-2)*(IMG_H-2). Rows 0-1 and columns 0-1 of every row produce none; no wrap-around windows.
- Frames are back-to-back with no gap cycles. Pixel (0,0) of the next frame may be accepted while the previous frame's last result is still in the pipeline.
- rst mid-frame: everything returns to reset values the next cycle, and any in-flight outputs are discarded. The next accepted pixel is (0,0).

Test Plan:
1. IMG_W=5, IMG_H=4, SHIFT=0, RELU=0; identity kernel (tap4=1, others 0); pixels p=5r+c -> outputs 6,7,8,11,12,13 in order, out_last only on 13.
2. Same size; all taps=1; all pixels 255 -> six outputs of 2295.
3. Saturation: all taps=127, pixels=255 (sum 291465) -> 32767. All taps=-128 -> -32768 with RELU=0; rerun with RELU=1 -> 0.
4. Rounding, SHIFT=2: tap4=6 vs tap4=-6 with center pixel 1 -> outputs 2 and -1.
5. Backpressure: out_ready toggled randomly (including 10 consecutive low cycles) during frames back-to-back -> in_ready falls within 1 cycle of stall; output sequence bit-identical to the unstalled run; count 6 per frame.
6. Assert rst after 7 accepted pixels, then send a full frame while changing coef mid-frame -> exactly 6 outputs equal to test 1 using the coef sampled at (0,0).
